// File: rtl/pe_launch_seq_if.sv
// Host-facing command/status bundle of the tile launch sequencer.
interface pe_launch_seq_if #(
  parameter int NUM_PE        = 4,
  parameter int CNT_WIDTH     = 16,
  parameter int STAGGER_WIDTH = 4
);
  localparam int PW = CNT_WIDTH + STAGGER_WIDTH + $clog2(NUM_PE) + 1;

  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [CNT_WIDTH-1:0]     cfg_run_len;
  logic [STAGGER_WIDTH-1:0] cfg_stagger;
  logic [NUM_PE-1:0]        cfg_mask;
  logic                     hold;
  logic                     abort;
  logic [NUM_PE-1:0]        ap_start;
  logic                     busy;
  logic                     done;
  logic                     aborted;
  logic [PW-1:0]            progress;

  modport master (
    output cfg_valid, cfg_run_len, cfg_stagger, cfg_mask, hold, abort,
    input  cfg_ready, ap_start, busy, done, aborted, progress
  );

  modport slave (
    input  cfg_valid, cfg_run_len, cfg_stagger, cfg_mask, hold, abort,
    output cfg_ready, ap_start, busy, done, aborted, progress
  );
endinterface

// File: rtl/pe_launch_seq.sv
// Staggered ap_start launch sequencer: ramps tile enables up, holds each for an
// identical window, ramps them down in the same order, then pulses done.
module pe_launch_seq #(
  parameter int NUM_PE        = 4,
  parameter int CNT_WIDTH     = 16,
  parameter int STAGGER_WIDTH = 4
) (
  input logic            clk,
  input logic            reset,
  pe_launch_seq_if.slave bus
);
  localparam int PW = CNT_WIDTH + STAGGER_WIDTH + $clog2(NUM_PE) + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                   state, state_n;
  logic [PW-1:0]            t, t_n;
  logic [PW-1:0]            eff_s, eff_l, span, w, t_end, lo;
  logic [STAGGER_WIDTH-1:0] s_q;
  logic [CNT_WIDTH-1:0]     l_q;
  logic [NUM_PE-1:0]        mask_q, eff_mask, ap_q, ap_n;
  logic                     aborted_q, aborted_n;
  logic                     accept, gate;

  assign accept = (state == IDLE) && bus.cfg_valid;

  // On the accept edge the window is computed from the live command fields.
  always_comb begin
    eff_s    = accept ? PW'(bus.cfg_stagger) : PW'(s_q);
    eff_l    = accept ? PW'(bus.cfg_run_len) : PW'(l_q);
    eff_mask = accept ? bus.cfg_mask : mask_q;
    span     = PW'(NUM_PE - 1) * eff_s;
    w        = span + eff_l;
    t_end    = span + w;
  end

  always_comb begin
    state_n   = state;
    t_n       = t;
    aborted_n = aborted_q;
    gate      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          t_n       = '0;
          aborted_n = 1'b0;
          if (t_end == '0) begin
            state_n = DONE;
          end else begin
            state_n = ACTIVE;
            gate    = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (bus.abort) begin
          state_n   = DONE;
          aborted_n = 1'b1;
        end else if (!bus.hold) begin
          t_n = t + 1'b1;
          if (t == t_end - 1'b1) state_n = DONE;
          else                   gate    = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Enable for the upcoming cycle is evaluated against the counter value that
  // cycle will carry; a sampled hold repeats t with all enables forced low.
  always_comb begin
    ap_n = '0;
    lo   = '0;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      lo      = PW'(i) * eff_s;
      ap_n[i] = gate && eff_mask[i] && (t_n >= lo) && (t_n < lo + w);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      t         <= '0;
      ap_q      <= '0;
      aborted_q <= 1'b0;
      s_q       <= '0;
      l_q       <= '0;
      mask_q    <= '0;
    end else begin
      state     <= state_n;
      t         <= t_n;
      ap_q      <= ap_n;
      aborted_q <= aborted_n;
      if (accept) begin
        s_q    <= bus.cfg_stagger;
        l_q    <= bus.cfg_run_len;
        mask_q <= bus.cfg_mask;
      end
    end
  end

  assign bus.cfg_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.aborted   = aborted_q;
  assign bus.ap_start  = ap_q;
  assign bus.progress  = t;
endmodule

// File: tb/tb_pe_launch_seq.sv
// Directed bench for pe_launch_seq; cycle 0 ends at the command-accept edge.
module tb_pe_launch_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  pe_launch_seq_if #(.NUM_PE(4), .CNT_WIDTH(16), .STAGGER_WIDTH(4)) bus ();

  pe_launch_seq #(.NUM_PE(4), .CNT_WIDTH(16), .STAGGER_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         first_c[4], last_c[4], cnt_c[4];
  int         done_cyc, busy_cnt;
  logic       done_ab, ready_after, ab_after;
  logic [3:0] done_ap, held_or;
  logic [31:0] prog5;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One command, then observe up to 40 cycles; hold active in [hold_lo,hold_hi].
  task automatic run(input logic [3:0] s, input logic [15:0] l, input logic [3:0] m,
                     input int hold_lo, input int hold_hi, input int abort_c);
    for (int i = 0; i < 4; i++) begin
      first_c[i] = 0; last_c[i] = 0; cnt_c[i] = 0;
    end
    done_cyc = 0; busy_cnt = 0; done_ab = 1'b0; ready_after = 1'b0;
    ab_after = 1'b0; done_ap = '0; held_or = '0; prog5 = '0;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b1; bus.cfg_stagger = s; bus.cfg_run_len = l; bus.cfg_mask = m;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      bus.cfg_valid = 1'b0;
      bus.hold  = (c >= hold_lo) && (c <= hold_hi);
      bus.abort = (c == abort_c);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (bus.ap_start[i]) begin
          if (first_c[i] == 0) first_c[i] = c;
          last_c[i] = c;
          cnt_c[i]++;
        end
      end
      if (bus.busy) busy_cnt++;
      if (c > hold_lo && c <= hold_hi + 1) held_or |= bus.ap_start;
      if (c == 5) prog5 = 32'(bus.progress);
      if (done_cyc != 0 && c == done_cyc + 1) begin
        ready_after = bus.cfg_ready;
        ab_after    = bus.aborted;
        break;
      end
      if (bus.done) begin
        done_cyc = c; done_ab = bus.aborted; done_ap = bus.ap_start;
      end
    end
    bus.hold = 1'b0; bus.abort = 1'b0;
  endtask

  initial begin
    bus.cfg_valid = 1'b0; bus.cfg_run_len = '0; bus.cfg_stagger = '0;
    bus.cfg_mask = '0; bus.hold = 1'b0; bus.abort = 1'b0;
    #12;
    check_eq("rst_ready", 32'(bus.cfg_ready), 32'd1);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_ap", 32'(bus.ap_start), 32'd0);
    check_eq("rst_progress", 32'(bus.progress), 32'd0);
    @(negedge clk); reset = 1'b0;

    // S=2 L=3 mask=1111: W=9, T_END=15
    run(4'd2, 16'd3, 4'hF, 0, -1, 0);
    check_eq("s1_t0_first", first_c[0], 1);
    check_eq("s1_t0_last", last_c[0], 9);
    check_eq("s1_t3_first", first_c[3], 7);
    check_eq("s1_t3_last", last_c[3], 15);
    check_eq("s1_t1_cnt", cnt_c[1], 9);
    check_eq("s1_done_cyc", done_cyc, 16);
    check_eq("s1_done_ab", 32'(done_ab), 32'd0);
    check_eq("s1_done_ap", 32'(done_ap), 32'd0);
    check_eq("s1_ready_after", 32'(ready_after), 32'd1);
    check_eq("s1_busy_cnt", busy_cnt, 16);
    check_eq("s1_progress5", prog5, 32'd4);

    // S=0 L=0: no enables, done in cycle 1
    run(4'd0, 16'd0, 4'hF, 0, -1, 0);
    check_eq("z_ap_cnt", cnt_c[0] + cnt_c[1] + cnt_c[2] + cnt_c[3], 0);
    check_eq("z_done_cyc", done_cyc, 1);
    check_eq("z_busy_cnt", busy_cnt, 1);

    // Hold in cycles 4-6
    run(4'd2, 16'd3, 4'hF, 4, 6, 0);
    check_eq("h_ap_during_hold", 32'(held_or), 32'd0);
    check_eq("h_t0_cnt", cnt_c[0], 9);
    check_eq("h_t3_cnt", cnt_c[3], 9);
    check_eq("h_t0_last", last_c[0], 12);
    check_eq("h_t3_first", first_c[3], 10);
    check_eq("h_t3_last", last_c[3], 18);
    check_eq("h_done_cyc", done_cyc, 19);

    // Abort in cycle 5
    run(4'd2, 16'd3, 4'hF, 0, -1, 5);
    check_eq("a_done_cyc", done_cyc, 6);
    check_eq("a_done_ab", 32'(done_ab), 32'd1);
    check_eq("a_done_ap", 32'(done_ap), 32'd0);
    check_eq("a_ready_after", 32'(ready_after), 32'd1);
    check_eq("a_aborted_kept", 32'(ab_after), 32'd1);
    check_eq("a_t0_cnt", cnt_c[0], 5);
    check_eq("a_t2_cnt", cnt_c[2], 1);
    check_eq("a_t3_cnt", cnt_c[3], 0);

    // Abort and hold together in cycle 5
    run(4'd2, 16'd3, 4'hF, 5, 5, 5);
    check_eq("ah_done_cyc", done_cyc, 6);
    check_eq("ah_done_ab", 32'(done_ab), 32'd1);

    // S=1 L=0: W=3, tile 0 falls as tile 3 rises
    run(4'd1, 16'd0, 4'hF, 0, -1, 0);
    check_eq("l0_t0_last", last_c[0], 3);
    check_eq("l0_t3_first", first_c[3], 4);
    check_eq("l0_done_cyc", done_cyc, 7);

    // Second command while busy, then asynchronous reset in cycle 8
    @(posedge clk); #1;
    bus.cfg_valid = 1'b1; bus.cfg_stagger = 4'd2; bus.cfg_run_len = 16'd3; bus.cfg_mask = 4'hF;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        bus.cfg_stagger = 4'd0; bus.cfg_run_len = 16'd0; bus.cfg_mask = 4'h1;
      end
      if (c == 7) begin
        @(negedge clk);
        check_eq("r_ap_c7", 32'(bus.ap_start), 32'hF);
        check_eq("r_progress_c7", 32'(bus.progress), 32'd6);
        check_eq("r_ready_busy", 32'(bus.cfg_ready), 32'd0);
      end
      if (c == 8) begin
        #1 reset = 1'b1;
        #1;
        check_eq("r_async_ap", 32'(bus.ap_start), 32'd0);
        check_eq("r_async_busy", 32'(bus.busy), 32'd0);
        check_eq("r_async_done", 32'(bus.done), 32'd0);
        check_eq("r_async_aborted", 32'(bus.aborted), 32'd0);
        check_eq("r_async_ready", 32'(bus.cfg_ready), 32'd1);
        check_eq("r_async_progress", 32'(bus.progress), 32'd0);
      end
    end
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    reset = 1'b0;

    // mask=0101 S=1 L=2: W=5, T_END=8
    run(4'd1, 16'd2, 4'b0101, 0, -1, 0);
    check_eq("m_t1_cnt", cnt_c[1], 0);
    check_eq("m_t3_cnt", cnt_c[3], 0);
    check_eq("m_t2_first", first_c[2], 3);
    check_eq("m_t2_last", last_c[2], 7);
    check_eq("m_t0_cnt", cnt_c[0], 5);
    check_eq("m_done_cyc", done_cyc, 9);
    check_eq("m_done_ab", 32'(done_ab), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
